// File: rtl/therm_n1_memory_arbiter.sv
// Arbitrates the single memory port between fetch (read-only) and LSU (read/write).
// Optional THERM_N1_ARB_ROUND_ROBIN_EN: alternate winners on contention instead of LSU priority.
module therm_n1_memory_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset_neg,
  input  logic                  i_fetch_req,
  input  logic [ADDR_WIDTH-1:0] i_fetch_address,
  output logic                  o_fetch_grant,
  output logic                  o_fetch_rvalid,
  output logic [DATA_WIDTH-1:0] o_fetch_rdata,
  input  logic                  i_lsu_req,
  input  logic                  i_lsu_write,
  input  logic [ADDR_WIDTH-1:0] i_lsu_address,
  input  logic [DATA_WIDTH-1:0] i_lsu_wdata,
  output logic                  o_lsu_grant,
  output logic                  o_lsu_rvalid,
  output logic [DATA_WIDTH-1:0] o_lsu_rdata,
  output logic                  o_mem_chip_enable,
  output logic                  o_mem_write_enable,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_data_store,
  input  logic [DATA_WIDTH-1:0] i_mem_data_load,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_owner_lsu, w_owner_lsu;
  logic                  r_write, w_write;
  logic                  w_arb_ok, w_pick_lsu, w_pick_fetch;
  logic                  w_fetch_grant, w_lsu_grant, w_fetch_rvalid, w_lsu_rvalid;
  logic                  w_ce, w_we, w_busy;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_store, w_fetch_rdata, w_lsu_rdata;
`ifdef THERM_N1_ARB_ROUND_ROBIN_EN
  logic                  r_last_lsu, w_last_lsu;
`endif

  // Winner selection among live requests.
  always_comb begin
`ifdef THERM_N1_ARB_ROUND_ROBIN_EN
    w_pick_lsu = i_lsu_req && (!i_fetch_req || !r_last_lsu);
`else
    w_pick_lsu = i_lsu_req;
`endif
    w_pick_fetch = i_fetch_req && !w_pick_lsu;
  end

  // Next state and next registered outputs; grant is issued one cycle before ACCESS.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_owner_lsu    = r_owner_lsu;
    w_write        = r_write;
    w_arb_ok       = 1'b0;
    w_fetch_grant  = 1'b0;
    w_lsu_grant    = 1'b0;
    w_fetch_rvalid = 1'b0;
    w_lsu_rvalid   = 1'b0;
    w_ce           = 1'b0;
    w_we           = 1'b0;
    w_addr         = o_mem_address;
    w_store        = o_mem_data_store;
    w_fetch_rdata  = o_fetch_rdata;
    w_lsu_rdata    = o_lsu_rdata;
`ifdef THERM_N1_ARB_ROUND_ROBIN_EN
    w_last_lsu     = r_last_lsu;
`endif
    case (r_state)
      S_IDLE: begin
        if (o_fetch_grant || o_lsu_grant) begin
          w_state_nxt = S_ACCESS;
          w_owner_lsu = o_lsu_grant;
          w_write     = o_lsu_grant && i_lsu_write;
          w_addr      = o_lsu_grant ? i_lsu_address : i_fetch_address;
          w_store     = o_lsu_grant ? i_lsu_wdata : '0;
          w_ce        = 1'b1;
          w_we        = o_lsu_grant && i_lsu_write;
        end else begin
          w_arb_ok = 1'b1;
        end
      end
      S_ACCESS: begin
        if (r_write) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_W'(MEM_LATENCY);
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_RESP;
          if (r_owner_lsu) w_lsu_rdata = i_mem_data_load;
          else             w_fetch_rdata = i_mem_data_load;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_arb_ok    = 1'b1;
      end
    endcase

    if (w_arb_ok) begin
      w_lsu_grant   = w_pick_lsu;
      w_fetch_grant = w_pick_fetch;
`ifdef THERM_N1_ARB_ROUND_ROBIN_EN
      if (w_pick_lsu || w_pick_fetch) w_last_lsu = w_pick_lsu;
`endif
    end

    w_fetch_rvalid = (w_state_nxt == S_RESP) && (r_state != S_RESP) && !w_owner_lsu;
    w_lsu_rvalid   = (w_state_nxt == S_RESP) && (r_state != S_RESP) && w_owner_lsu;
    w_busy         = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset_neg) begin
    if (!i_reset_neg) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      r_owner_lsu        <= 1'b0;
      r_write            <= 1'b0;
      o_fetch_grant      <= 1'b0;
      o_lsu_grant        <= 1'b0;
      o_fetch_rvalid     <= 1'b0;
      o_lsu_rvalid       <= 1'b0;
      o_fetch_rdata      <= '0;
      o_lsu_rdata        <= '0;
      o_mem_chip_enable  <= 1'b0;
      o_mem_write_enable <= 1'b0;
      o_mem_address      <= '0;
      o_mem_data_store   <= '0;
      o_busy             <= 1'b0;
`ifdef THERM_N1_ARB_ROUND_ROBIN_EN
      r_last_lsu         <= 1'b1;
`endif
    end else begin
      r_state            <= w_state_nxt;
      r_cnt              <= w_cnt_nxt;
      r_owner_lsu        <= w_owner_lsu;
      r_write            <= w_write;
      o_fetch_grant      <= w_fetch_grant;
      o_lsu_grant        <= w_lsu_grant;
      o_fetch_rvalid     <= w_fetch_rvalid;
      o_lsu_rvalid       <= w_lsu_rvalid;
      o_fetch_rdata      <= w_fetch_rdata;
      o_lsu_rdata        <= w_lsu_rdata;
      o_mem_chip_enable  <= w_ce;
      o_mem_write_enable <= w_we;
      o_mem_address      <= w_addr;
      o_mem_data_store   <= w_store;
      o_busy             <= w_busy;
`ifdef THERM_N1_ARB_ROUND_ROBIN_EN
      r_last_lsu         <= w_last_lsu;
`endif
    end
  end

endmodule

// File: tb/tb_therm_n1_memory_arbiter.sv
// Random two-requester traffic checked cycle-by-cycle against a transaction-level timing model.
module tb_therm_n1_memory_arbiter;

  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int          LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fetch_req = 1'b0, lsu_req = 1'b0, lsu_write = 1'b0;
  logic [AW-1:0] fetch_address = '0, lsu_address = '0;
  logic [DW-1:0] lsu_wdata = '0, mem_data_load = '0;
  logic          fetch_grant, fetch_rvalid, lsu_grant, lsu_rvalid;
  logic          mem_ce, mem_we, busy;
  logic [DW-1:0] fetch_rdata, lsu_rdata, mem_data_store;
  logic [AW-1:0] mem_address;

  always #5 clk = ~clk;

  therm_n1_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
    .i_clock(clk), .i_reset_neg(rst_n),
    .i_fetch_req(fetch_req), .i_fetch_address(fetch_address),
    .o_fetch_grant(fetch_grant), .o_fetch_rvalid(fetch_rvalid), .o_fetch_rdata(fetch_rdata),
    .i_lsu_req(lsu_req), .i_lsu_write(lsu_write), .i_lsu_address(lsu_address),
    .i_lsu_wdata(lsu_wdata), .o_lsu_grant(lsu_grant), .o_lsu_rvalid(lsu_rvalid),
    .o_lsu_rdata(lsu_rdata), .o_mem_chip_enable(mem_ce), .o_mem_write_enable(mem_we),
    .o_mem_address(mem_address), .o_mem_data_store(mem_data_store),
    .i_mem_data_load(mem_data_load), .o_busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: one outstanding transaction described by its grant and response cycles.
  bit            have_txn, t_lsu, t_write, last_lsu, force_f;
  int            t_g, t_rv, last_rv;
  logic [AW-1:0] t_addr, e_addr;
  logic [DW-1:0] t_wdata, t_rdata, e_store, e_frdata, e_lrdata;
  logic [DW-1:0] mem [16];
  bit            f_hold, f_rel, l_hold, l_rel;
  logic          p_freq, p_lreq, p_lwrite;
  logic [AW-1:0] p_faddr, p_laddr;
  logic [DW-1:0] p_lwdata;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'({$urandom_range(0, 15), 3'b000});
    return a;
  endfunction

  task automatic model_reset();
    have_txn = 1'b0; last_rv = -1; last_lsu = 1'b1;
    e_addr = '0; e_store = '0; e_frdata = '0; e_lrdata = '0;
    f_hold = 1'b0; f_rel = 1'b0; l_hold = 1'b0; l_rel = 1'b0;
    p_freq = 1'b0; p_lreq = 1'b0; p_lwrite = 1'b0;
    p_faddr = '0; p_laddr = '0; p_lwdata = '0;
  endtask

  // Grants follow a request held in the previous cycle, once the previous response is done.
  task automatic model_step();
    bit gl;
    if ((p_freq || p_lreq) && (cyc - 1) >= last_rv) begin
`ifdef THERM_N1_ARB_ROUND_ROBIN_EN
      gl = p_lreq && (!p_freq || !last_lsu);
`else
      gl = p_lreq;
`endif
      last_lsu = gl;
      have_txn = 1'b1;
      t_lsu    = gl;
      t_write  = gl && p_lwrite;
      t_addr   = gl ? p_laddr : p_faddr;
      t_wdata  = gl ? p_lwdata : '0;
      t_g      = cyc;
      t_rv     = cyc + 2 + (t_write ? 0 : LAT);
      last_rv  = t_rv;
    end
    if (have_txn && cyc == t_g + 1) begin
      e_addr  = t_addr;
      e_store = t_wdata;
      if (t_write) mem[t_addr[6:3]] = t_wdata;
      else         t_rdata = mem[t_addr[6:3]];
    end
    if (have_txn && cyc == t_rv && !t_write) begin
      if (t_lsu) e_lrdata = t_rdata;
      else       e_frdata = t_rdata;
    end
  endtask

  task automatic check_zero(input string pfx);
    check_val({pfx, "_fetch_grant"}, 64'(fetch_grant), 64'd0);
    check_val({pfx, "_lsu_grant"}, 64'(lsu_grant), 64'd0);
    check_val({pfx, "_fetch_rvalid"}, 64'(fetch_rvalid), 64'd0);
    check_val({pfx, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'd0);
    check_val({pfx, "_ce"}, 64'(mem_ce), 64'd0);
    check_val({pfx, "_we"}, 64'(mem_we), 64'd0);
    check_val({pfx, "_busy"}, 64'(busy), 64'd0);
    check_val({pfx, "_addr"}, mem_address, 64'd0);
    check_val({pfx, "_store"}, mem_data_store, 64'd0);
    check_val({pfx, "_frdata"}, fetch_rdata, 64'd0);
    check_val({pfx, "_lrdata"}, lsu_rdata, 64'd0);
  endtask

  task automatic run_cycle(input bit en);
    bit gf_now, gl_now, ce_e;
    @(posedge clk);
    model_step();
    #1;
    gf_now = have_txn && t_g == cyc && !t_lsu;
    gl_now = have_txn && t_g == cyc && t_lsu;
    // Fetch requester: hold until granted, occasionally withdraw while not being granted.
    if (f_rel) begin
      fetch_req = 1'b0; f_rel = 1'b0; f_hold = 1'b0; fetch_address = {$urandom, $urandom};
    end else if (f_hold) begin
      if (gf_now) f_rel = 1'b1;
      else if (en && $urandom_range(0, 15) == 0) begin fetch_req = 1'b0; f_hold = 1'b0; end
    end else if (force_f || (en && $urandom_range(0, 2) == 0)) begin
      fetch_req = 1'b1; f_hold = 1'b1; force_f = 1'b0; fetch_address = rand_addr();
    end
    // LSU requester, same protocol with random load/store.
    if (l_rel) begin
      lsu_req = 1'b0; l_rel = 1'b0; l_hold = 1'b0;
      lsu_address = {$urandom, $urandom}; lsu_wdata = {$urandom, $urandom}; lsu_write = 1'($urandom);
    end else if (l_hold) begin
      if (gl_now) l_rel = 1'b1;
      else if (en && $urandom_range(0, 15) == 0) begin lsu_req = 1'b0; l_hold = 1'b0; end
    end else if (en && $urandom_range(0, 2) == 0) begin
      lsu_req = 1'b1; l_hold = 1'b1; lsu_write = 1'($urandom);
      lsu_address = rand_addr(); lsu_wdata = {$urandom, $urandom};
    end
    if (have_txn && !t_write && cyc == t_g + 1 + LAT) mem_data_load = t_rdata;
    else mem_data_load = {$urandom, $urandom};
    @(negedge clk);
    ce_e = have_txn && cyc == t_g + 1;
    check_val("fetch_grant", 64'(fetch_grant), 64'(gf_now));
    check_val("lsu_grant", 64'(lsu_grant), 64'(gl_now));
    check_val("mem_ce", 64'(mem_ce), 64'(ce_e));
    check_val("mem_we", 64'(mem_we), 64'(ce_e && t_write));
    check_val("mem_address", mem_address, e_addr);
    check_val("mem_data_store", mem_data_store, e_store);
    check_val("fetch_rvalid", 64'(fetch_rvalid), 64'(have_txn && cyc == t_rv && !t_lsu));
    check_val("lsu_rvalid", 64'(lsu_rvalid), 64'(have_txn && cyc == t_rv && t_lsu));
    check_val("fetch_rdata", fetch_rdata, e_frdata);
    check_val("lsu_rdata", lsu_rdata, e_lrdata);
    check_val("busy", 64'(busy), 64'(have_txn && cyc >= t_g + 1 && cyc <= t_rv));
    p_freq = fetch_req; p_lreq = lsu_req; p_lwrite = lsu_write;
    p_faddr = fetch_address; p_laddr = lsu_address; p_lwdata = lsu_wdata;
    cyc++;
  endtask

  // Drain, start a fetch read and pull reset while it waits on memory.
  task automatic reset_in_wait();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) run_cycle(1'b0);
    force_f = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      run_cycle(1'b0);
      hit = have_txn && !t_lsu && !t_write && (cyc - 1) == t_g + 2;
    end
    check_val("reach_wait", 64'(hit), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    fetch_req = 1'b0; lsu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    force_f = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
    model_reset();
    force_f = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) run_cycle(1'b1);
    reset_in_wait();
    for (int i = 0; i < 600; i++) run_cycle(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
